// File: rtl/tanh_backward.sv
// tanh_backward
//   Backward pass of tanh: grad_out = g_in * (1 - y_in^2), where y_in is the
//   saved forward output. The datapath is a 3-stage valid-tagged pipeline
//   (S1 square, S2 subtract, S3 multiply/round) with ready/valid on both sides.
//   A single "advance" condition moves every stage at once, so a stalled output
//   freezes the whole pipe and no sample is dropped or duplicated.
//
// Ports
//   clk          : rising-edge clock
//   reset        : synchronous, active-high reset
//   in_valid     : upstream sample valid
//   in_ready     : a sample is accepted this cycle (in_valid && in_ready)
//   y_in         : tanh forward output, signed Q2.8 (256 = 1.0)
//   g_in         : upstream gradient, signed Q5.5 (32 = 1.0)
//   out_valid    : result valid
//   out_ready    : downstream accepts the result
//   grad_out     : g * (1 - y^2), signed Q5.5, registered
//   clamp_out    : the result's y_in lay outside [-1.0, +1.0] and was clamped
//   sample_count : number of completed output handshakes (wraps)
module tanh_backward #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] g_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] grad_out,
  output logic              clamp_out,
  output logic [CNT_W-1:0]  sample_count
);

  // y^2 in Q.16 needs 17 bits because 1.0^2 = 65536 is reachable.
  localparam int SQ_W = 17;
  // 1 - y^2 in Q.8 spans 0..256.
  localparam int D_W  = 9;
  // g (Q5.5) * d (Q.8) product, Q5.13.
  localparam int P_W  = DATA_W + D_W;

  localparam logic signed [DATA_W-1:0] Y_MAX = DATA_W'(256);
  localparam logic signed [DATA_W-1:0] Y_MIN = -Y_MAX;

  // Stage registers
  logic              s1_valid_q;
  logic [SQ_W-1:0]   s1_ysq_q;
  logic [DATA_W-1:0] s1_g_q;
  logic              s1_clamp_q;

  logic              s2_valid_q;
  logic [D_W-1:0]    s2_d_q;
  logic [DATA_W-1:0] s2_g_q;
  logic              s2_clamp_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] grad_q;
  logic              clamp_q;
  logic [CNT_W-1:0]  count_q;

  // Next-state values
  logic                     advance;
  logic signed [DATA_W-1:0] y_s;
  logic signed [DATA_W-1:0] yc;
  logic signed [SQ_W-1:0]   yc_ext;
  logic                     s1_clamp_d;
  logic [SQ_W-1:0]          s1_ysq_d;
  logic [D_W-1:0]           s2_d_d;
  logic signed [P_W-1:0]    g_ext;
  logic signed [P_W-1:0]    d_ext;
  logic signed [P_W-1:0]    prod;
  logic [DATA_W-1:0]        grad_d;

  // Output register empty or being drained: every stage may shift.
  assign advance = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    // S1: clamp y to [-1.0, +1.0] then square. The square of a value in
    // [-256, 256] is non-negative and at most 65536, so the low 17 bits of a
    // 17-bit signed multiply hold it exactly as an unsigned number.
    y_s        = $signed(y_in);
    yc         = y_s;
    s1_clamp_d = 1'b0;
    if (y_s > Y_MAX) begin
      yc         = Y_MAX;
      s1_clamp_d = 1'b1;
    end else if (y_s < Y_MIN) begin
      yc         = Y_MIN;
      s1_clamp_d = 1'b1;
    end
    yc_ext   = {{(SQ_W-DATA_W){yc[DATA_W-1]}}, yc};
    s1_ysq_d = yc_ext * yc_ext;

    // S2: 1 - y^2, Q.16 down to Q.8 (truncating). y^2 <= 65536, so no wrap.
    s2_d_d = D_W'((17'h10000 - s1_ysq_q) >> 8);

    // S3: signed g times unsigned d, then round half up back to Q5.5.
    // |d| <= 1.0 keeps |result| <= |g|, so truncating to DATA_W is exact.
    g_ext  = {{D_W{s2_g_q[DATA_W-1]}}, s2_g_q};
    d_ext  = {{DATA_W{1'b0}}, s2_d_q};
    prod   = g_ext * d_ext;
    grad_d = DATA_W'((prod + $signed(P_W'(128))) >>> 8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_ysq_q    <= '0;
      s1_g_q      <= '0;
      s1_clamp_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_d_q      <= '0;
      s2_g_q      <= '0;
      s2_clamp_q  <= 1'b0;
      out_valid_q <= 1'b0;
      grad_q      <= '0;
      clamp_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      if (advance) begin
        // Valid bits always follow the previous stage so bubbles propagate.
        s1_valid_q  <= in_valid;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        if (in_valid) begin
          s1_ysq_q   <= s1_ysq_d;
          s1_g_q     <= g_in;
          s1_clamp_q <= s1_clamp_d;
        end
        if (s1_valid_q) begin
          s2_d_q     <= s2_d_d;
          s2_g_q     <= s1_g_q;
          s2_clamp_q <= s1_clamp_q;
        end
        // Result registers only change when a real sample lands in them.
        if (s2_valid_q) begin
          grad_q  <= grad_d;
          clamp_q <= s2_clamp_q;
        end
      end
      if (out_valid_q && out_ready) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign grad_out     = grad_q;
  assign clamp_out    = clamp_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_tanh_backward.sv
// tb_tanh_backward
//   Directed bench for tanh_backward. Expected results come from a table of
//   hand-computed vectors; a monitor pairs every output handshake with the
//   expected value queued at the matching input handshake. A second instance
//   with a 4-bit counter shares all inputs and is used to observe wrap-around.
module tb_tanh_backward;

  localparam int DW = 10;

  typedef struct {
    int grad;
    int clamp;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] y_in;
  logic [DW-1:0] g_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] grad_out;
  logic          clamp_out;
  logic [15:0]   sample_count;

  logic          in_ready_s;
  logic          out_valid_s;
  logic [DW-1:0] grad_out_s;
  logic          clamp_out_s;
  logic [3:0]    sample_count_s;

  int   total;
  int   bad;
  exp_t drv_exp;
  exp_t exp_q[$];
  int   run_cur;
  int   last_run;

  tanh_backward #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .y_in         (y_in),
    .g_in         (g_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .grad_out     (grad_out),
    .clamp_out    (clamp_out),
    .sample_count (sample_count)
  );

  tanh_backward #(.DATA_W(DW), .CNT_W(4)) dut_small (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready_s),
    .y_in         (y_in),
    .g_in         (g_in),
    .out_valid    (out_valid_s),
    .out_ready    (out_ready),
    .grad_out     (grad_out_s),
    .clamp_out    (clamp_out_s),
    .sample_count (sample_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // Present one sample and hold it until the DUT accepts it.
  task automatic send(input int y, input int g, input int eg, input int ec);
    logic acc;
    y_in     = DW'(y);
    g_in     = DW'(g);
    drv_exp  = '{eg, ec};
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", int'(in_ready), 1);
  endtask

  // Output monitor: one line per delivered result.
  initial begin
    exp_t e;
    run_cur  = 0;
    last_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        run_cur  = 0;
        last_run = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_result", int'(out_valid), 0);
          end else begin
            e = exp_q.pop_front();
            $display("result grad=%0d clamp=%0d (exp %0d/%0d)",
                     $signed(grad_out), clamp_out, e.grad, e.clamp);
            chk("grad", int'($signed(grad_out)), e.grad);
            chk("clamp", int'(clamp_out), e.clamp);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(drv_exp);
        if (out_valid) begin
          run_cur++;
        end else begin
          if (run_cur > 0) last_run = run_cur;
          run_cur = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int vy[10] = '{0, 128, 256, 300, -300, 100, -200, 16, -256, -512};
  int vg[10] = '{32, -64, 511, 100, 100, 50, -1, -300, 100, 1};
  int ve[10] = '{32, -48, 0, 0, 0, 42, 0, -299, 0, 0};
  int vc[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1};

  initial begin
    int lat;
    int g0;
    total    = 0;
    bad      = 0;
    y_in     = '0;
    g_in     = '0;
    drv_exp  = '{0, 0};
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_grad", int'(grad_out), 0);
    chk("rst_clamp", int'(clamp_out), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Single-sample latency
    y_in     = DW'(0);
    g_in     = DW'(32);
    drv_exp  = '{32, 0};
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    chk("latency", lat, 3);
    cyc(3);
    chk("latency_count", int'(sample_count), 1);

    // Back-to-back stream of ten directed vectors
    do_reset();
    for (int i = 0; i < 10; i++) send(vy[i], vg[i], ve[i], vc[i]);
    in_valid = 1'b0;
    cyc(6);
    chk("stream_run", last_run, 10);
    chk("stream_count", int'(sample_count), 10);
    chk("stream_drained", exp_q.size(), 0);

    // Output stall with three samples in the pipe
    do_reset();
    out_ready = 1'b0;
    send(-128, 511, 383, 0);
    send(300, 100, 0, 1);
    send(128, -64, -48, 0);
    in_valid = 1'b0;
    g0 = int'($signed(grad_out));
    chk("stall_head", g0, 383);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_grad_hold", int'($signed(grad_out)), g0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cyc(6);
    chk("stall_count", int'(sample_count), 3);
    chk("stall_drained", exp_q.size(), 0);

    // Reset with two samples in flight
    do_reset();
    send(0, 32, 32, 0);
    send(100, 50, 42, 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_count", int'(sample_count), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", int'(out_valid), 0);
    end
    chk("midrst_count_after", int'(sample_count), 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 15; i++) send(0, 32, 32, 0);
    in_valid = 1'b0;
    cyc(6);
    chk("wrap_pre", int'(sample_count_s), 15);
    send(0, 32, 32, 0);
    in_valid = 1'b0;
    cyc(6);
    chk("wrap_zero", int'(sample_count_s), 0);
    chk("wrap_main", int'(sample_count), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
